// File: rtl/core_pkg.sv
// core_pkg: constants and state encoding shared by the PC sequencer, its
// adder, and any trace/difftest monitor that reuses the adder.
//   XLEN     : datapath / PC width
//   RESET_PC : architectural PC after reset
//   PC_STEP  : sequential fetch increment
//   seq_state_e : fetch/execute sequencing states
package core_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          PC_STEP  = 4;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } seq_state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch request/response channel between the PC sequencer
// (master) and the IFU (slave).
//   ifu_req_valid  : master -> slave, fetch request valid
//   ifu_req_ready  : slave -> master, request accepted
//   ifu_req_addr   : master -> slave, fetch address
//   ifu_resp_valid : slave -> master, fetched instruction returned
interface pc_sequencer_if #(parameter int XLEN = core_pkg::XLEN);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_resp_valid;

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid
  );
endinterface

// File: rtl/pc_sequencer_adder.sv
// pc_adder: purely combinational next-PC computation.
//   a_src_i    : operand A select, 0 = PC_STEP, 1 = imm_i
//   b_src_i    : operand B select, 0 = pc_i,    1 = rs1_i (jalr style)
//   pc_i/imm_i/rs1_i : operand sources
//   next_pc_o  : (A+B) mod 2^XLEN, bit0 cleared when B is rs1
//   misalign_o : next_pc_o[1] set while CHECK_ALIGN is enabled
module pc_adder
  import core_pkg::*;
#(
  parameter int XLEN        = core_pkg::XLEN,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            a_src_i,
  input  logic            b_src_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);
  logic [XLEN-1:0] opa, opb, sum;

  always_comb begin
    opa = a_src_i ? imm_i : XLEN'(PC_STEP);
    opb = b_src_i ? rs1_i : pc_i;
    // Carry out is dropped on purpose: wrap-around is architecturally silent.
    sum = opa + opb;
    next_pc_o = {sum[XLEN-1:1], sum[0] & ~b_src_i};
    misalign_o = CHECK_ALIGN && next_pc_o[1];
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and sequences fetch for a
// single-cycle core: BOOT -> REQ -> WAIT -> EXEC -> REQ ..., HALT terminal.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pc_a_src, pc_b_src  : next-PC adder operand selects
//   imm, rs1            : next-PC adder operand values
//   exec_done, halt_req : EXU completion strobe and stop request (EXEC only)
//   ifu                 : fetch request/response channel (master side)
//   inst_valid          : one-cycle pulse when the fetched instruction arrives
//   pc                  : architectural PC
//   misalign, halted    : sticky fault / stop flags
module pc_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN        = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = core_pkg::RESET_PC,
  parameter bit              CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_a_src,
  input  logic              pc_b_src,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   rs1,
  input  logic              exec_done,
  input  logic              halt_req,
  pc_sequencer_if.master    ifu,
  output logic              inst_valid,
  output logic [XLEN-1:0]   pc,
  output logic              misalign,
  output logic              halted
);
  seq_state_e      state_q, state_d;
  logic            boot_q, boot_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            halted_q, halted_d;

  logic [XLEN-1:0] next_pc;
  logic            next_mis;

  pc_adder #(.XLEN(XLEN), .CHECK_ALIGN(CHECK_ALIGN)) u_adder (
    .a_src_i    (pc_a_src),
    .b_src_i    (pc_b_src),
    .pc_i       (pc_q),
    .imm_i      (imm),
    .rs1_i      (rs1),
    .next_pc_o  (next_pc),
    .misalign_o (next_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_q     <= 1'b0;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_q     <= boot_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_d     = boot_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    halted_d   = halted_q;
    inst_valid = 1'b0;
    case (state_q)
      // boot_q marks that the reset-release cycle has gone by idle.
      BOOT: begin
        boot_d = 1'b1;
        if (boot_q) state_d = REQ;
      end
      REQ: if (ifu.ifu_req_ready) state_d = WAIT;
      WAIT: if (ifu.ifu_resp_valid) begin
        inst_valid = 1'b1;
        state_d    = EXEC;
      end
      EXEC: if (exec_done) begin
        if (halt_req) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (next_mis) begin
          misalign_d = 1'b1;
          state_d    = HALT;
        end else begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Request valid is decoded from state only, so it has no combinational
  // dependence on ready/resp and drops with the async reset.
  assign ifu.ifu_req_valid = (state_q == REQ);
  assign ifu.ifu_req_addr  = pc_q;
  assign pc                = pc_q;
  assign misalign          = misalign_q;
  assign halted            = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_a_src = 1'b0, pc_b_src = 1'b0;
  logic [31:0] imm = '0, rs1 = '0;
  logic        exec_done = 1'b0, halt_req = 1'b0;
  logic        inst_valid, misalign, halted;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  // Reference state: PC the sequencer should hold, and sticky flags.
  logic [31:0] exp_pc = RST_PC;
  bit          exp_mis = 0, exp_halt = 0;

  pc_sequencer_if ifu_if ();

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_a_src   (pc_a_src),
    .pc_b_src   (pc_b_src),
    .imm        (imm),
    .rs1        (rs1),
    .exec_done  (exec_done),
    .halt_req   (halt_req),
    .ifu        (ifu_if),
    .inst_valid (inst_valid),
    .pc         (pc),
    .misalign   (misalign),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Next PC from the architectural rule: A + B mod 2^32, jalr clears bit0.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input bit a, input bit b,
                                           input logic [31:0] im, input logic [31:0] r1);
    longint unsigned s;
    s = longint'(a ? im : 32'd4) + longint'(b ? r1 : cur);
    s = s % 64'h1_0000_0000;
    if (b) s = s & ~64'd1;
    return s[31:0];
  endfunction

  // Entered on a negedge; returns on a negedge with the DUT in EXEC.
  task automatic fetch(input int rdly, input int resp_dly, input bit stray);
    int n = 0;
    while (!ifu_if.ifu_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", ifu_if.ifu_req_valid, 1);
    chk("req_addr", ifu_if.ifu_req_addr, exp_pc);
    for (int i = 0; i < rdly; i++) begin
      ifu_if.ifu_req_ready  = 1'b0;
      ifu_if.ifu_resp_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_valid", ifu_if.ifu_req_valid, 1);
      chk("bp_addr", ifu_if.ifu_req_addr, exp_pc);
      chk("bp_inst", inst_valid, 0);
    end
    ifu_if.ifu_resp_valid = 1'b0;
    ifu_if.ifu_req_ready  = 1'b1;
    @(negedge clk);
    ifu_if.ifu_req_ready = 1'b0;
    chk("req_drop", ifu_if.ifu_req_valid, 0);
    for (int i = 0; i < resp_dly; i++) begin
      if (stray && i == 0) begin
        exec_done = 1'b1; pc_a_src = 1'b1; pc_b_src = 1'b0; imm = 32'h40;
      end
      @(negedge clk);
      exec_done = 1'b0;
      chk("wait_inst", inst_valid, 0);
      chk("wait_pc", pc, exp_pc);
    end
    ifu_if.ifu_resp_valid = 1'b1;
    #1 chk("inst_pulse", inst_valid, 1);
    @(negedge clk);
    ifu_if.ifu_resp_valid = 1'b0;
    #1 chk("inst_one", inst_valid, 0);
  endtask

  // Entered on a negedge in EXEC; returns one cycle after exec_done.
  task automatic do_exec(input int edly, input bit a, input bit b, input logic [31:0] im,
                         input logic [31:0] r1, input bit hreq);
    logic [31:0] nxt;
    for (int i = 0; i < edly; i++) @(negedge clk);
    pc_a_src = a; pc_b_src = b; imm = im; rs1 = r1; halt_req = hreq;
    exec_done = 1'b1;
    nxt = ref_next(exp_pc, a, b, im, r1);
    if (hreq) exp_halt = 1;
    else if (nxt[1]) exp_mis = 1;
    else exp_pc = nxt;
    @(negedge clk);
    exec_done = 1'b0; halt_req = 1'b0;
    chk("exec_pc", pc, exp_pc);
    chk("exec_mis", misalign, exp_mis);
    chk("exec_halt", halted, exp_halt);
    chk("exec_valid", ifu_if.ifu_req_valid, !(exp_mis || exp_halt));
    if (!(exp_mis || exp_halt)) chk("exec_addr", ifu_if.ifu_req_addr, exp_pc);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b0;
    exp_pc = RST_PC; exp_mis = 0; exp_halt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_frozen();
    logic [31:0] held = pc;
    for (int i = 0; i < 5; i++) begin
      ifu_if.ifu_resp_valid = 1'b1;
      exec_done = 1'b1;
      @(negedge clk);
      chk("halt_valid", ifu_if.ifu_req_valid, 0);
      chk("halt_inst", inst_valid, 0);
      chk("halt_pc", pc, held);
    end
    ifu_if.ifu_resp_valid = 1'b0;
    exec_done = 1'b0;
  endtask

  initial begin
    ifu_if.ifu_req_ready  = 1'b1;
    ifu_if.ifu_resp_valid = 1'b0;
    #12;
    chk("rst_pc", pc, RST_PC);
    chk("rst_valid", ifu_if.ifu_req_valid, 0);
    chk("rst_inst", inst_valid, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_halt", halted, 0);

    // Release with ready held high: request appears two cycles later.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_idle", ifu_if.ifu_req_valid, 0);
    @(negedge clk);
    chk("boot_req", ifu_if.ifu_req_valid, 1);
    chk("boot_addr", ifu_if.ifu_req_addr, 32'h8000_0000);
    fetch(0, 0, 0);

    // Directed targets.
    do_exec(0, 0, 0, 32'h0, 32'h0, 0);
    chk("seq_addr", exp_pc, 32'h8000_0004);
    fetch(0, 0, 0);
    do_exec(1, 1, 0, 32'hC, 32'h0, 0);
    fetch(0, 1, 0);
    do_exec(0, 1, 0, 32'hFFFF_FFF8, 32'h0, 0);
    chk("branch_addr", ifu_if.ifu_req_addr, 32'h8000_0008);
    fetch(0, 0, 0);
    do_exec(0, 1, 1, 32'h4, 32'h8000_0101, 0);
    chk("jalr_addr", ifu_if.ifu_req_addr, 32'h8000_0104);
    // Backpressure plus stray exec_done in WAIT.
    fetch(5, 2, 1);
    do_exec(0, 0, 1, 32'h0, 32'hFFFF_FFFC, 0);
    chk("wrap_addr", ifu_if.ifu_req_addr, 32'h0);

    // Randomized aligned traffic.
    for (int k = 0; k < 40; k++) begin
      bit a, b;
      logic [31:0] im, r1;
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      im = $urandom & 32'hFFFF_FFFC;
      r1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      fetch($urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      do_exec($urandom_range(0, 2), a, b, im, r1, 0);
    end

    // Misaligned branch target stops the sequencer with pc held.
    fetch(0, 0, 0);
    do_exec(0, 1, 0, 32'h2, 32'h0, 0);
    chk("mis_flag", misalign, 1);
    check_frozen();
    chk("mis_sticky", misalign, 1);

    // Halt request after reset.
    reset_release();
    fetch(0, 1, 0);
    do_exec(0, 0, 0, 32'h0, 32'h0, 0);
    fetch(1, 1, 0);
    do_exec(0, 1, 0, 32'h2, 32'h0, 1);
    chk("halt_flag", halted, 1);
    chk("halt_nomis", misalign, 0);
    chk("halt_pcfrz", pc, 32'h8000_0004);
    check_frozen();

    // Async reset in the middle of a pending request.
    reset_release();
    fetch(0, 0, 0);
    do_exec(0, 0, 0, 32'h0, 32'h0, 0);
    ifu_if.ifu_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ifu_if.ifu_req_valid, 0);
    chk("arst_pc", pc, RST_PC);
    exp_pc = RST_PC;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer end of the branch-condition interface: takes the PC-adder operand selects (pc_a_src, pc_b_src) plus imm/rs1 and owns the architectural PC register.
- Sequences the single-cycle core's instruction fetch with a request/response handshake to the IFU.
- Applies the next-PC update once per retired instruction.
- Flags misaligned targets and halts on request.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h8000_0000, PC value loaded on reset
CHECK_ALIGN, 1, 1 = raise misalign on next_pc[1]==1; 0 = ignore

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
pc_a_src  in  1  adder input A select: 0 = constant 4, 1 = imm
pc_b_src  in  1  adder input B select: 0 = current PC, 1 = rs1
imm  in  XLEN  decoded immediate
rs1  in  XLEN  register-file rs1 value
exec_done  in  1  EXU strobe: instruction complete, selects/imm/rs1 valid this cycle
halt_req  in  1  ebreak/stop request, sampled with exec_done
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  IFU accepts request
ifu_req_addr  out  XLEN  fetch address (= pc)
ifu_resp_valid  in  1  fetched instruction returned
inst_valid  out  1  one-cycle pulse: instruction available to decode/EXU
pc  out  XLEN  architectural PC
misalign  out  1  sticky misaligned-target flag
halted  out  1  sticky halt flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: pc=RESET_PC, state=BOOT, ifu_req_valid=0, inst_valid=0, misalign=0, halted=0.
- State BOOT: one idle cycle after rst_n deasserts, then go to REQ. No request is issued in the reset-release cycle.
- State REQ:
  - ifu_req_valid=1, ifu_req_addr=pc.
  - Handshake completes on valid&&ready, then go to WAIT.
  - valid stays high and addr stays stable until accepted.
- State WAIT:
  - Wait for ifu_resp_valid.
  - In the cycle it is seen, pulse inst_valid=1 for exactly one cycle and go to EXEC.
  - ifu_resp_valid outside WAIT is ignored.
- State EXEC: wait for exec_done. exec_done outside EXEC is ignored. On exec_done:
  - A = pc_a_src ? imm : 4; B = pc_b_src ? rs1 : pc.
  - next = (A+B) mod 2^XLEN, so wrap-around is silent.
  - If pc_b_src==1 (jalr), clear next[0].
  - If halt_req: pc unchanged, halted=1, go to HALT. halt_req takes priority over misalign.
  - Else if CHECK_ALIGN && next[1]: pc unchanged, misalign=1, go to HALT.
  - Else: pc<=next on the clock edge and go to REQ. Minimum latency is 1 cycle from exec_done to the new ifu_req_valid.
- Operand combinations: {a,b}=00 gives pc+4, 10 gives pc+imm, 11 gives rs1+imm (bit0 cleared). The unused combination 01 gives rs1+4 (bit0 cleared) and is not an error.
- State HALT: terminal. All requests are deasserted and pc is frozen. Only rst_n exits.
- Reset mid-operation: async return to BOOT; a pending request is dropped immediately. The IFU must tolerate a dropped valid.
- No combinational path from ifu_req_ready or ifu_resp_valid to ifu_req_valid.

Decomposition:
- Shared package (core_pkg): state enum {BOOT, REQ, WAIT, EXEC, HALT}; XLEN; RESET_PC; PC_STEP=4.
- One sub-module: pc_adder. Combinational operand muxes, adder, jalr bit0 clear and misalign detect. Reusable by the trace/difftest monitor.

Test Plan:
- Reset release with ifu_req_ready=1 and ifu_resp_valid returned 1 cycle later:
  - ifu_req_valid rises exactly 2 cycles after rst_n high, with addr 0x8000_0000.
  - inst_valid pulses once.
- Sequential step: exec_done with a=0,b=0 at pc=0x8000_0000 -> next request addr 0x8000_0004.
- Branch and jump targets:
  - a=1,b=0, imm=0xFFFF_FFF8 at pc=0x8000_0010 -> addr 0x8000_0008.
  - a=1,b=1, rs1=0x8000_0101, imm=0x4 -> addr 0x8000_0104 (bit0 cleared).
- Misalign: a=1,b=0, imm=0x2 -> misalign=1, halted state entered, pc stays at the old value, no further ifu_req_valid.
- Backpressure and stray inputs:
  - ifu_req_ready low for 5 cycles -> valid held high, addr stable.
  - exec_done pulsed during WAIT -> ignored, pc unchanged.
- Halt and async reset:
  - halt_req with exec_done -> halted=1, pc frozen.
  - rst_n asserted mid-REQ -> ifu_req_valid drops asynchronously and pc=RESET_PC.
